// File: rtl/alu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// alu_bus_arbiter
//
// Round-robin arbiter for eight ALUs sharing one result bus through an external
// 8-to-1 one-hot mux. One owner at a time holds the bus. It releases the bus in
// one of three ways:
//   - it signals done, and its word is captured into data_out;
//   - it drops its request;
//   - its hold time runs out (forced release).
// Every release is followed by at least one idle cycle, so the bus has time to
// turn around before the next owner drives it.
//
// Parameters
//   BUS_SIZE   width of the shared result bus
//   MAX_HOLD   maximum cycles one owner may hold the bus (1..255)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req        per-requester bus request, bit i = requester i
//   done       owner's transfer word is on the bus this cycle
//   data_in    output of the shared one-hot mux
//   sel        registered one-hot mux select, zero when there is no owner
//   grant_id   binary index of the owner, meaningful only while busy
//   busy       an owner currently holds the bus
//   data_out   word captured on the done cycle
//   data_valid one-cycle pulse qualifying a new data_out
//   timeout    one-cycle pulse on a forced release
// -----------------------------------------------------------------------------
module alu_bus_arbiter #(
   parameter int BUS_SIZE = 32,
   parameter int MAX_HOLD = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          req,
   input  logic                done,
   input  logic [BUS_SIZE-1:0] data_in,
   output logic [7:0]          sel,
   output logic [2:0]          grant_id,
   output logic                busy,
   output logic [BUS_SIZE-1:0] data_out,
   output logic                data_valid,
   output logic                timeout
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t              state_q,      state_d;
   logic [7:0]          sel_q,        sel_d;
   logic [2:0]          grant_id_q,   grant_id_d;
   logic                busy_q,       busy_d;
   logic [BUS_SIZE-1:0] data_out_q,   data_out_d;
   logic                data_valid_q, data_valid_d;
   logic                timeout_q,    timeout_d;
   logic [7:0]          hold_q,       hold_d;
   logic [2:0]          last_q,       last_d;

   // Round-robin search results.
   logic       win_found;
   logic [2:0] win_idx;
   logic [2:0] cand_idx;

   // The owner has held the bus for MAX_HOLD cycles once the counter reaches
   // MAX_HOLD-1, because the counter starts at 0 on the first granted cycle.
   logic hold_expired;
   assign hold_expired = (hold_q == 8'(MAX_HOLD - 1));

   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path leaves
      // one unassigned and no latch is inferred.
      state_d      = state_q;
      sel_d        = sel_q;
      grant_id_d   = grant_id_q;
      busy_d       = busy_q;
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;
      timeout_d    = 1'b0;
      hold_d       = hold_q;
      last_d       = last_q;
      win_found    = 1'b0;
      win_idx      = 3'd0;
      cand_idx     = 3'd0;

      // Search upward from last+1. The 3-bit sum wraps modulo 8, so the eighth
      // candidate is the previous owner itself, which is checked last.
      for (int i = 1; i <= 8; i++) begin
         cand_idx = last_q + 3'(i);
         if (!win_found && req[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end

      case (state_q)
         IDLE: begin
            // done is deliberately ignored while there is no owner.
            if (win_found) begin
               state_d    = GRANT;
               sel_d      = 8'd1 << win_idx;
               grant_id_d = win_idx;
               busy_d     = 1'b1;
               hold_d     = 8'd0;
               last_d     = win_idx;
            end
         end

         GRANT: begin
            // Release causes in priority order: done, then timeout, then the
            // request dropping. Any release returns to IDLE, which forces the
            // one-cycle bus turnaround.
            if (done) begin
               data_out_d   = data_in;
               data_valid_d = 1'b1;
               state_d      = IDLE;
            end else if (hold_expired) begin
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else if (!req[grant_id_q]) begin
               state_d = IDLE;
            end else begin
               hold_d = hold_q + 8'd1;
            end

            if (state_d == IDLE) begin
               sel_d  = 8'd0;
               busy_d = 1'b0;
               hold_d = 8'd0;
            end
         end

         default: begin
            state_d = IDLE;
            sel_d   = 8'd0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // The FSM and all of its registered outputs update here, with reset taking
   // priority over every other input.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the values from before this edge.
      if (rst) begin
         state_q      <= IDLE;
         sel_q        <= 8'd0;
         grant_id_q   <= 3'd0;
         busy_q       <= 1'b0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         timeout_q    <= 1'b0;
         hold_q       <= 8'd0;
         last_q       <= 3'd7;  // requester 0 wins first after reset
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         grant_id_q   <= grant_id_d;
         busy_q       <= busy_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         timeout_q    <= timeout_d;
         hold_q       <= hold_d;
         last_q       <= last_d;
      end
   end

   assign sel        = sel_q;
   assign grant_id   = grant_id_q;
   assign busy       = busy_q;
   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign timeout    = timeout_q;

endmodule

// File: tb/tb_alu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_bus_arbiter
//
// Directed testbench for alu_bus_arbiter (BUS_SIZE=32, MAX_HOLD=15). Inputs
// change 1 ns after each rising edge. Outputs are checked at the same point,
// so each check sees the registers loaded by the edge just taken.
// -----------------------------------------------------------------------------
module tb_alu_bus_arbiter;

   localparam int BUS_SIZE = 32;
   localparam int MAX_HOLD = 15;

   logic                clk = 1'b0;
   logic                rst;
   logic [7:0]          req;
   logic                done;
   logic [BUS_SIZE-1:0] data_in;
   logic [7:0]          sel;
   logic [2:0]          grant_id;
   logic                busy;
   logic [BUS_SIZE-1:0] data_out;
   logic                data_valid;
   logic                timeout;

   int n_pass  = 0;
   int n_total = 0;

   alu_bus_arbiter #(
      .BUS_SIZE(BUS_SIZE),
      .MAX_HOLD(MAX_HOLD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .done      (done),
      .data_in   (data_in),
      .sel       (sel),
      .grant_id  (grant_id),
      .busy      (busy),
      .data_out  (data_out),
      .data_valid(data_valid),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
   endtask

   // Checks an owner's grant: one-hot select, matching index, busy high.
   task automatic check_grant(input string tag, input int id);
      logic [7:0] exp_sel;
      exp_sel = 8'd1 << id;
      check({tag, " sel"},      32'(sel),      32'(exp_sel));
      check({tag, " grant_id"}, 32'(grant_id), 32'(id));
      check({tag, " busy"},     32'(busy),     32'd1);
   endtask

   // Checks the bus is idle: select clear, busy low.
   task automatic check_idle(input string tag);
      check({tag, " sel"},  32'(sel),  32'd0);
      check({tag, " busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      rst     = 1'b1;
      req     = 8'h00;
      done    = 1'b0;
      data_in = '0;

      // Reset values.
      step();
      step();
      check_idle("rst");
      check("rst grant_id",   32'(grant_id),   32'd0);
      check("rst data_out",   data_out,        32'd0);
      check("rst data_valid", 32'(data_valid), 32'd0);
      check("rst timeout",    32'(timeout),    32'd0);
      rst = 1'b0;

      // Requesters 0 and 2: requester 0 wins first, then requester 2.
      req = 8'b0000_0101;
      step();
      check_grant("r029 first", 0);
      done    = 1'b1;
      data_in = 32'h0000_AAAA;
      step();
      check_idle("r029 release");
      check("r029 data_valid", 32'(data_valid), 32'd1);
      check("r029 data_out",   data_out,        32'h0000_AAAA);
      done = 1'b0;
      step();
      check_grant("r029 second", 2);
      check("r029 dv cleared", 32'(data_valid), 32'd0);
      done = 1'b1;
      step();
      done = 1'b0;
      req  = 8'h00;

      // All eight requesting: after reset, grants rotate 0..7 then back to 0,
      // with exactly one idle cycle between grants.
      rst = 1'b1;
      step();
      rst = 1'b0;
      req = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         step();
         check_grant($sformatf("r030 grant%0d", i), i % 8);
         step();
         check("r030 hold sel", 32'(sel), 32'(8'd1 << (i % 8)));
         done    = 1'b1;
         data_in = 32'(i);
         step();
         check_idle($sformatf("r030 turn%0d", i));
         check("r030 data_out", data_out, 32'(i));
         done = 1'b0;
      end
      req = 8'h00;
      step();
      check_idle("r030 quiet");

      // Owner 3 completes a transfer; data_valid lasts exactly one cycle.
      req = 8'b0000_1000;
      step();
      check_grant("r031", 3);
      data_in = 32'hDEAD_BEEF;
      done    = 1'b1;
      step();
      check("r031 data_out",   data_out,        32'hDEAD_BEEF);
      check("r031 data_valid", 32'(data_valid), 32'd1);
      check("r031 sel",        32'(sel),        32'd0);
      done = 1'b0;
      req  = 8'h00;
      step();
      check("r031 dv one cycle", 32'(data_valid), 32'd0);
      check("r031 data hold",    data_out,        32'hDEAD_BEEF);

      // Owner 5 holds without done: 15 granted cycles, then a forced release.
      req = 8'b0010_0000;
      step();
      check_grant("r032 cyc1", 5);
      for (int k = 2; k <= MAX_HOLD; k++) begin
         step();
         check($sformatf("r032 cyc%0d sel", k), 32'(sel), 32'h20);
         check("r032 no early timeout", 32'(timeout), 32'd0);
      end
      step();
      check_idle("r032 forced");
      check("r032 timeout",     32'(timeout),    32'd1);
      check("r032 no dv",       32'(data_valid), 32'd0);
      step();
      check("r032 timeout pulse", 32'(timeout), 32'd0);
      check_grant("r032 regrant", 5);
      // Hold again and assert done on the 15th cycle: done outranks timeout.
      for (int k = 2; k <= MAX_HOLD; k++) step();
      check("r032 cyc15 sel", 32'(sel), 32'h20);
      data_in = 32'h0000_5555;
      done    = 1'b1;
      step();
      check("r032 done dv",      32'(data_valid), 32'd1);
      check("r032 done timeout", 32'(timeout),    32'd0);
      check("r032 done data",    data_out,        32'h0000_5555);
      check_idle("r032 done");
      done = 1'b0;
      req  = 8'h00;
      step();

      // Owner 6 drops its request: silent release, data_out unchanged.
      req = 8'b0100_0000;
      step();
      check_grant("r033", 6);
      req = 8'h00;
      step();
      check_idle("r033 drop");
      check("r033 dv",       32'(data_valid), 32'd0);
      check("r033 timeout",  32'(timeout),    32'd0);
      check("r033 data_out", data_out,        32'h0000_5555);

      // done is ignored while idle.
      done    = 1'b1;
      data_in = 32'h0000_1234;
      step();
      check("idle done dv",   32'(data_valid), 32'd0);
      check("idle done data", data_out,        32'h0000_5555);
      check_idle("idle done");
      done = 1'b0;

      // Reset during owner 2's grant overrides a concurrent done.
      req = 8'b0000_0100;
      step();
      check_grant("r034 owner", 2);
      rst     = 1'b1;
      done    = 1'b1;
      data_in = 32'hFFFF_FFFF;
      step();
      check_idle("r034 rst");
      check("r034 grant_id",   32'(grant_id),   32'd0);
      check("r034 data_out",   data_out,        32'd0);
      check("r034 data_valid", 32'(data_valid), 32'd0);
      check("r034 timeout",    32'(timeout),    32'd0);
      rst  = 1'b0;
      done = 1'b0;
      req  = 8'b0000_0110;
      step();
      check_grant("r034 after rst", 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
